// File: rtl/reg_file_write_arbiter_if.sv
// Writeback request bundle between the two requesters and the register-file
// write arbiter.
//   req0_* : requester 0 (ALU result path)  valid/addr/data in, ready out
//   req1_* : requester 1 (memory load path) valid/addr/data in, ready out
// master modport: requester side; slave modport: arbiter side.
interface reg_file_write_arbiter_if #(
  parameter int unsigned DATA_W = 8,
  parameter int unsigned ADDR_W = 2
);

  logic              req0_valid;
  logic [ADDR_W-1:0] req0_addr;
  logic [DATA_W-1:0] req0_data;
  logic              req0_ready;

  logic              req1_valid;
  logic [ADDR_W-1:0] req1_addr;
  logic [DATA_W-1:0] req1_data;
  logic              req1_ready;

  modport master (
    output req0_valid, req0_addr, req0_data,
    output req1_valid, req1_addr, req1_data,
    input  req0_ready, req1_ready
  );

  modport slave (
    input  req0_valid, req0_addr, req0_data,
    input  req1_valid, req1_addr, req1_data,
    output req0_ready, req1_ready
  );

endinterface

// File: rtl/reg_file_write_arbiter.sv
// Shares the register file's single write port between two writeback
// requesters with round-robin arbitration, and clears every register after
// reset or on a clear command (the register file itself has no reset).
// Ports:
//   clk, rst_n       clock, asynchronous active-low reset
//   clear            synchronous request to re-run the clear sequence
//   req              requester handshakes (slave side); readies are combinational
//   rf_write_enable  registered write enable to the register file
//   rf_write_addr    registered write address
//   rf_write_data    registered write data
//   rf_write_src     registered source of current write (0: req0/clear, 1: req1)
//   init_done        registered, high once the clear sequence has completed
module reg_file_write_arbiter #(
  parameter int unsigned       DATA_W     = 8,
  parameter int unsigned       ADDR_W     = 2,
  parameter logic [DATA_W-1:0] INIT_VALUE = '0
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     clear,
  reg_file_write_arbiter_if.slave  req,
  output logic                     rf_write_enable,
  output logic [ADDR_W-1:0]        rf_write_addr,
  output logic [DATA_W-1:0]        rf_write_data,
  output logic                     rf_write_src,
  output logic                     init_done
);

  localparam int unsigned       NUM_REGS = 1 << ADDR_W;
  localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(NUM_REGS - 1);

  typedef enum logic {
    ST_INIT = 1'b0,
    ST_RUN  = 1'b1
  } state_t;

  state_t            state_q;
  state_t            state_d;
  logic [ADDR_W-1:0] init_idx_q;
  logic [ADDR_W-1:0] init_idx_d;
  logic              rr_ptr_q;
  logic              rr_ptr_d;

  logic              we_d;
  logic [ADDR_W-1:0] addr_d;
  logic [DATA_W-1:0] data_d;
  logic              src_d;
  logic              done_d;
  logic              gnt0;
  logic              gnt1;

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_INIT;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic; clear overrides everything and restarts the sweep
  always_comb begin
    state_d = state_q;
    if (clear) begin
      state_d = ST_INIT;
    end else if ((state_q == ST_INIT) && (init_idx_q == LAST_IDX)) begin
      state_d = ST_RUN;
    end
  end

  // Output / datapath logic: grants and next values of the output registers
  always_comb begin
    gnt0       = 1'b0;
    gnt1       = 1'b0;
    init_idx_d = init_idx_q;
    rr_ptr_d   = rr_ptr_q;
    we_d       = 1'b0;
    addr_d     = rf_write_addr;
    data_d     = rf_write_data;
    src_d      = rf_write_src;
    done_d     = init_done;

    if (clear) begin
      // No grant on a clear edge; addr/data/src hold, rr_ptr is kept.
      init_idx_d = '0;
      done_d     = 1'b0;
    end else if (state_q == ST_INIT) begin
      we_d       = 1'b1;
      addr_d     = init_idx_q;
      data_d     = INIT_VALUE;
      src_d      = 1'b0;
      init_idx_d = init_idx_q + ADDR_W'(1);
      if (init_idx_q == LAST_IDX) begin
        init_idx_d = '0;
        done_d     = 1'b1;
      end
    end else begin
      // rr_ptr names the requester favoured when both are valid
      gnt0 = req.req0_valid && (!req.req1_valid || !rr_ptr_q);
      gnt1 = req.req1_valid && (!req.req0_valid ||  rr_ptr_q);
      if (gnt0) begin
        we_d     = 1'b1;
        addr_d   = req.req0_addr;
        data_d   = req.req0_data;
        src_d    = 1'b0;
        rr_ptr_d = 1'b1;
      end else if (gnt1) begin
        we_d     = 1'b1;
        addr_d   = req.req1_addr;
        data_d   = req.req1_data;
        src_d    = 1'b1;
        rr_ptr_d = 1'b0;
      end
    end
  end

  assign req.req0_ready = gnt0;
  assign req.req1_ready = gnt1;

  // Output and bookkeeping registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      init_idx_q      <= '0;
      rr_ptr_q        <= 1'b0;
      rf_write_enable <= 1'b0;
      rf_write_addr   <= '0;
      rf_write_data   <= '0;
      rf_write_src    <= 1'b0;
      init_done       <= 1'b0;
    end else begin
      init_idx_q      <= init_idx_d;
      rr_ptr_q        <= rr_ptr_d;
      rf_write_enable <= we_d;
      rf_write_addr   <= addr_d;
      rf_write_data   <= data_d;
      rf_write_src    <= src_d;
      init_done       <= done_d;
    end
  end

endmodule

// File: tb/tb_reg_file_write_arbiter.sv
// Scoreboard bench for reg_file_write_arbiter: expected register-file writes
// are queued when a grant (or clear-sweep write) is expected and popped when
// the write appears on the rf_write_* outputs one edge later.
module tb_reg_file_write_arbiter;

  localparam int unsigned       DATA_W = 8;
  localparam int unsigned       ADDR_W = 2;
  localparam int unsigned       NREGS  = 1 << ADDR_W;
  localparam logic [DATA_W-1:0] INIT_V = 8'hA5;

  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] data;
    logic              src;
  } wr_t;

  logic              clk;
  logic              rst_n;
  logic              clear;
  logic              rf_write_enable;
  logic [ADDR_W-1:0] rf_write_addr;
  logic [DATA_W-1:0] rf_write_data;
  logic              rf_write_src;
  logic              init_done;

  wr_t exp_q[$];
  int  n_vec;
  int  n_miss;

  reg_file_write_arbiter_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) bus ();

  reg_file_write_arbiter #(
    .DATA_W    (DATA_W),
    .ADDR_W    (ADDR_W),
    .INIT_VALUE(INIT_V)
  ) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .clear          (clear),
    .req            (bus),
    .rf_write_enable(rf_write_enable),
    .rf_write_addr  (rf_write_addr),
    .rf_write_data  (rf_write_data),
    .rf_write_src   (rf_write_src),
    .init_done      (init_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_miss++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // One clock: drive inputs just after a falling edge, check readies, push
  // expected grants, then check the registered outputs after the rising edge.
  task automatic step(input logic v0, input logic [ADDR_W-1:0] a0, input logic [DATA_W-1:0] d0,
                      input logic v1, input logic [ADDR_W-1:0] a1, input logic [DATA_W-1:0] d1,
                      input logic clr, input logic er0, input logic er1, input logic edone);
    wr_t w;
    bus.req0_valid = v0;
    bus.req0_addr  = a0;
    bus.req0_data  = d0;
    bus.req1_valid = v1;
    bus.req1_addr  = a1;
    bus.req1_data  = d1;
    clear          = clr;
    #1;
    check_val("req0_ready", 32'(bus.req0_ready), 32'(er0));
    check_val("req1_ready", 32'(bus.req1_ready), 32'(er1));
    if (er0) exp_q.push_back(wr_t'{a0, d0, 1'b0});
    if (er1) exp_q.push_back(wr_t'{a1, d1, 1'b1});
    @(posedge clk);
    #1;
    check_val("rf_write_enable", 32'(rf_write_enable), 32'(exp_q.size() != 0));
    if (exp_q.size() != 0) begin
      w = exp_q.pop_front();
      if (rf_write_enable) begin
        check_val("rf_write_addr", 32'(rf_write_addr), 32'(w.addr));
        check_val("rf_write_data", 32'(rf_write_data), 32'(w.data));
        check_val("rf_write_src",  32'(rf_write_src),  32'(w.src));
      end
    end
    check_val("init_done", 32'(init_done), 32'(edone));
    @(negedge clk);
  endtask

  // Full clear sweep: addresses 0..NREGS-1 with INIT_V; readies must stay low.
  task automatic run_init(input logic v0, input logic [ADDR_W-1:0] a0, input logic [DATA_W-1:0] d0,
                          input logic v1, input logic [ADDR_W-1:0] a1, input logic [DATA_W-1:0] d1);
    for (int i = 0; i < int'(NREGS); i++) begin
      exp_q.push_back(wr_t'{ADDR_W'(i), INIT_V, 1'b0});
      step(v0, a0, d0, v1, a1, d1, 1'b0, 1'b0, 1'b0, i == int'(NREGS) - 1);
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    check_val({tag, "_we"},   32'(rf_write_enable), 32'(0));
    check_val({tag, "_addr"}, 32'(rf_write_addr),   32'(0));
    check_val({tag, "_data"}, 32'(rf_write_data),   32'(0));
    check_val({tag, "_src"},  32'(rf_write_src),    32'(0));
    check_val({tag, "_done"}, 32'(init_done),       32'(0));
  endtask

  initial begin
    n_vec          = 0;
    n_miss         = 0;
    rst_n          = 1'b0;
    clear          = 1'b0;
    bus.req0_valid = 1'b0;
    bus.req0_addr  = '0;
    bus.req0_data  = '0;
    bus.req1_valid = 1'b0;
    bus.req1_addr  = '0;
    bus.req1_data  = '0;

    repeat (2) @(negedge clk);
    check_reset_outputs("reset");
    rst_n = 1'b1;

    // Clear sweep from reset, then one idle edge
    run_init(1'b0, 2'd0, 8'h00, 1'b0, 2'd0, 8'h00);
    step(1'b0, 2'd0, 8'h00, 1'b0, 2'd0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b1);

    // Continuous contention: grants 0,1,0,1 starting from rr_ptr = 0
    step(1'b1, 2'd1, 8'h11, 1'b1, 2'd3, 8'h33, 1'b0, 1'b1, 1'b0, 1'b1);
    step(1'b1, 2'd1, 8'h11, 1'b1, 2'd3, 8'h33, 1'b0, 1'b0, 1'b1, 1'b1);
    step(1'b1, 2'd1, 8'h11, 1'b1, 2'd3, 8'h33, 1'b0, 1'b1, 1'b0, 1'b1);
    step(1'b1, 2'd1, 8'h11, 1'b1, 2'd3, 8'h33, 1'b0, 1'b0, 1'b1, 1'b1);

    // req0 alone writes addr 2 / 3C; leaves rr_ptr favouring requester 1
    step(1'b1, 2'd2, 8'h3C, 1'b0, 2'd0, 8'h00, 1'b0, 1'b1, 1'b0, 1'b1);
    step(1'b0, 2'd0, 8'h00, 1'b0, 2'd0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b1);

    // Clear in RUN with both valid: no grant, sweep again, then req1 first
    step(1'b1, 2'd0, 8'h5A, 1'b1, 2'd3, 8'hC3, 1'b1, 1'b0, 1'b0, 1'b0);
    run_init(1'b1, 2'd0, 8'h5A, 1'b1, 2'd3, 8'hC3);
    step(1'b1, 2'd0, 8'h5A, 1'b1, 2'd3, 8'hC3, 1'b0, 1'b0, 1'b1, 1'b1);
    step(1'b1, 2'd0, 8'h5A, 1'b0, 2'd3, 8'hC3, 1'b0, 1'b1, 1'b0, 1'b1);
    // Same address back to back: both serialized in grant order
    step(1'b0, 2'd0, 8'h00, 1'b1, 2'd2, 8'hE1, 1'b0, 1'b0, 1'b1, 1'b1);
    step(1'b1, 2'd2, 8'hE2, 1'b0, 2'd0, 8'h00, 1'b0, 1'b1, 1'b0, 1'b1);
    step(1'b0, 2'd0, 8'h00, 1'b0, 2'd0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b1);

    // Reset mid-sweep at init_idx = 2: outputs drop immediately
    step(1'b0, 2'd0, 8'h00, 1'b0, 2'd0, 8'h00, 1'b1, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 2; i++) begin
      exp_q.push_back(wr_t'{ADDR_W'(i), INIT_V, 1'b0});
      step(1'b0, 2'd0, 8'h00, 1'b0, 2'd0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0);
    end
    rst_n = 1'b0;
    #1;
    check_reset_outputs("async_rst");
    @(negedge clk);
    rst_n = 1'b1;

    // req1 waiting through the restarted sweep, accepted right after init_done
    run_init(1'b0, 2'd0, 8'h00, 1'b1, 2'd1, 8'h77);
    step(1'b0, 2'd0, 8'h00, 1'b1, 2'd1, 8'h77, 1'b0, 1'b0, 1'b1, 1'b1);
    step(1'b0, 2'd0, 8'h00, 1'b0, 2'd0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b1);

    check_val("scoreboard_empty", 32'(exp_q.size()), 32'(0));

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule

// File: doc/reg_file_write_arbiter.md
# reg_file_write_arbiter

Shares the register file's single write port between two writeback requesters (requester 0: ALU result path; requester 1: memory load path) and sequences a clear of every register after reset or on command, because the register file itself has no reset. Sits directly in front of the register file's write_addr/write_data/write_enable inputs. It drives those inputs from registered outputs, one write per cycle. Round-robin arbitration guarantees neither requester starves.

## Interface
- DATA_W, 8, width of write data
- ADDR_W, 2, width of register address; register count NUM_REGS = 2**ADDR_W
- INIT_VALUE, 0, value written to every register during the clear sequence

- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous, active-low reset
- clear  in  1  synchronous request to re-run the clear sequence
- req0_valid  in  1  requester 0 has a write pending
- req0_addr  in  ADDR_W  requester 0 target register
- req0_data  in  DATA_W  requester 0 write data
- req0_ready  out  1  requester 0 write accepted this cycle (combinational)
- req1_valid / req1_addr / req1_data / req1_ready: same as requester 0, for requester 1
- rf_write_enable  out  1  to register file write_enable (registered)
- rf_write_addr  out  ADDR_W  to register file write_addr (registered)
- rf_write_data  out  DATA_W  to register file write_data (registered)
- rf_write_src  out  1  source of the current write: 0 = requester 0 or clear, 1 = requester 1 (registered)
- init_done  out  1  high once the clear sequence has completed (registered)

## Operation
- State machine with two states:
  - INIT: clear sequence.
  - RUN: arbitration.
- Internal registers:
  - init_idx, ADDR_W bits.
  - rr_ptr, 1 bit; the value names the requester favoured on a tie.
- Reset, asynchronous on rst_n low:
  - state = INIT, init_idx = 0, rr_ptr = 0.
  - rf_write_enable = 0, rf_write_addr = 0, rf_write_data = 0, rf_write_src = 0, init_done = 0.
- INIT, each clock edge:
  - Load rf_write_enable = 1, rf_write_addr = init_idx, rf_write_data = INIT_VALUE, rf_write_src = 0.
  - init_idx increments.
  - When init_idx == NUM_REGS-1: state goes to RUN, init_done goes to 1, init_idx goes to 0.
- Both readies are 0 in INIT and in any cycle where clear = 1.
- RUN, ready generation (combinational):
  - Only one requester valid: that requester's ready = 1.
  - Both valid: requester rr_ptr gets ready = 1, the other gets 0.
  - Neither valid: both readies 0.
- RUN, accepted write (valid && ready) at the clock edge:
  - Load rf_write_enable = 1, rf_write_addr = reqN_addr, rf_write_data = reqN_data, rf_write_src = N.
  - rr_ptr becomes ~N.
- RUN, no accepted write: rf_write_enable goes to 0; addr, data and src hold their values.
- clear = 1 at an edge, in either state:
  - state = INIT, init_idx = 0, init_done = 0, rf_write_enable = 0.
  - No grant is made on that edge. In INIT this restarts the count from address 0.
- rr_ptr is unchanged by clear; only rst_n resets it.
- A requester that is not granted must hold valid, addr and data stable until ready.
- The block stores nothing beyond the current output registers; there is no queueing.

## Timing
- Grant-to-write latency is one cycle: a request accepted at edge k appears on the rf_write_* outputs after edge k. The register file captures it at edge k+1.
- Clear sequence, with edge 1 = first rising edge after rst_n deasserts:
  - Edges 1 to NUM_REGS load addresses 0 to NUM_REGS-1.
  - init_done rises on edge NUM_REGS.
  - The first request can be accepted in the cycle after edge NUM_REGS.
- Sustained throughput: one write per cycle. Under continuous contention, grants strictly alternate 0,1,0,1.
- Two requests to the same address: both are serialized; the later grant wins in the register file.
- rst_n asserted mid-sequence or mid-grant: all outputs are forced to their reset values immediately (asynchronously).

## Test plan
- Reset then idle, ADDR_W=2, INIT_VALUE=8'hA5 -> rf_write_addr 0,1,2,3 on edges 1-4 with enable=1 and data=A5; init_done=1 after edge 4; enable=0 on edge 5.
- After init, req0 alone writes addr 2 data 8'h3C -> req0_ready=1 the same cycle; next cycle enable=1, addr=2, data=3C, src=0.
- Both valid for 4 cycles (req0: addr1/8'h11, req1: addr3/8'h33) -> grants in order 0,1,0,1 (rr_ptr=0 after reset); the ungranted requester's ready=0 each cycle.
- clear pulsed for one cycle in RUN with both requesters valid -> both readies 0 that cycle, init_done drops, then addresses 0-3 are rewritten with INIT_VALUE, then arbitration resumes with the rr_ptr value held from before clear.
- rst_n pulsed low at init_idx=2 -> outputs immediately 0; after release the sequence restarts at address 0.
- req1 valid during INIT -> req1_ready stays 0 until the cycle after init_done rises; then the write is accepted with its data unchanged.
